hlsm_host: RTL
==============

HLSM_HOST -- requirements
Module: hlsm_host

Interface
REQ-001 SHALL provide parameter DW, default 32, operand/result width.
REQ-002 SHALL provide parameter TIMEOUT, default 255, max WAIT_DONE cycles before abort (1..65535).
REQ-003 SHALL use reset Rst, synchronous, active-high; clock Clk.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  host job request.
REQ-007 req_ready  output  1  block can accept a job.
REQ-008 req_a, req_b, req_c  input  DW each  job operands.
REQ-009 hs_start  output  1  Start pulse to datapath responder.
REQ-010 hs_done  input  1  Done from responder; may be held high indefinitely.
REQ-011 hs_a, hs_b, hs_c  output  DW each  registered operands driven to responder.
REQ-012 hs_z, hs_x  input  DW each  responder results.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_z, rsp_x  output  DW each  captured results.
REQ-016 rsp_err  output  1  job aborted by timeout.
REQ-017 job_cnt  output  16  completed-job count.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE, RESP; all outputs registered.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on req_valid&&req_ready, SHALL latch req_a/b/c into hs_a/b/c and go to LAUNCH.
REQ-021 LAUNCH: hs_start SHALL be 1 for exactly one cycle (accept at cycle N -> hs_start high cycle N+1 only), then WAIT_DONE.
REQ-022 hs_a/b/c SHALL stay stable from LAUNCH until return to IDLE.
REQ-023 WAIT_DONE: an arm flag SHALL clear on entry and set once hs_done is sampled 0; hs_done=1 SHALL complete the job only while armed, so a Done held high from a prior job is ignored.
REQ-024 On armed hs_done=1: SHALL capture hs_z/hs_x into rsp_z/rsp_x, rsp_err=0, go to RESP next cycle.
REQ-025 RESP: rsp_valid=1 with rsp_z/rsp_x/rsp_err stable until rsp_ready=1; on that cycle, go to IDLE and increment job_cnt.
REQ-026 job_cnt SHALL wrap 16'hFFFF -> 0; increments on timed-out jobs too.
REQ-027 req_valid during LAUNCH/WAIT_DONE/RESP SHALL be ignored; req_valid with rsp_ready in RESP -> job accepted no earlier than the following IDLE cycle.
REQ-028 hs_start SHALL never assert outside LAUNCH.

Reset
REQ-029 Rst SHALL force IDLE, clear arm flag and timeout counter, and drive all outputs to 0 except req_ready, which SHALL be 1 the cycle after reset release.
REQ-030 Rst asserted mid-job (any state) SHALL abort the job with no rsp_valid, no job_cnt increment, hs_start=0 the next cycle.

Configuration
REQ-031 Macro HLSM_HOST_TIMEOUT_EN defined: a 16-bit counter SHALL count WAIT_DONE cycles; on reaching TIMEOUT without completion, SHALL set rsp_err=1, rsp_z=rsp_x=0, go to RESP.
REQ-032 Macro HLSM_HOST_TIMEOUT_EN undefined: no counter; WAIT_DONE SHALL wait indefinitely; rsp_err SHALL be constant 0; TIMEOUT unused.

Verification
REQ-033 Reset, then a=3,b=4,c=5 accepted; responder returns z=22,x=8 three cycles after Start -> one-cycle hs_start, rsp_z=22, rsp_x=8, rsp_err=0, job_cnt=1.
REQ-034 Responder holds hs_done=1 from previous job; second job -> no completion until hs_done seen 0 then 1.
REQ-035 rsp_ready held 0 for 10 cycles -> rsp_valid and results stable throughout; req_valid ignored; req_ready=0.
REQ-036 With HLSM_HOST_TIMEOUT_EN, TIMEOUT=8, hs_done never asserted -> rsp_valid after 8 WAIT_DONE cycles, rsp_err=1, rsp_z=rsp_x=0.
REQ-037 Rst pulsed during WAIT_DONE -> IDLE, job_cnt unchanged at 0, no rsp_valid; next job completes normally.
REQ-038 Preload 65535 completions -> next completion reads job_cnt=0.

Source files
------------

// File: rtl/hlsm_host.sv
// hlsm_host: host-side job sequencer that launches a datapath responder with a
// one-cycle start pulse, waits for its done, and hands the results to a consumer.
// Optional WAIT_DONE timeout when HLSM_HOST_TIMEOUT_EN is defined.
module hlsm_host #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   input  logic [DW-1:0] req_c,
   output logic          hs_start,
   input  logic          hs_done,
   output logic [DW-1:0] hs_a,
   output logic [DW-1:0] hs_b,
   output logic [DW-1:0] hs_c,
   input  logic [DW-1:0] hs_z,
   input  logic [DW-1:0] hs_x,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_z,
   output logic [DW-1:0] rsp_x,
   output logic          rsp_err,
   output logic [15:0]   job_cnt
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("hlsm_host: TIMEOUT must lie within 1..65535");
   end

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} state_t;

   state_t        state, state_nxt;
   logic          armed, armed_nxt;
   logic          req_ready_nxt, hs_start_nxt;
   logic [DW-1:0] hs_a_nxt, hs_b_nxt, hs_c_nxt;
   logic          rsp_valid_nxt, rsp_err_nxt;
   logic [DW-1:0] rsp_z_nxt, rsp_x_nxt;
   logic [15:0]   job_cnt_nxt;

`ifdef HLSM_HOST_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] tmo_cnt, tmo_cnt_nxt;
`endif

   // NOTE: every value is given a default before the case so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      armed_nxt     = armed;
      hs_a_nxt      = hs_a;
      hs_b_nxt      = hs_b;
      hs_c_nxt      = hs_c;
      rsp_valid_nxt = rsp_valid;
      rsp_z_nxt     = rsp_z;
      rsp_x_nxt     = rsp_x;
      rsp_err_nxt   = rsp_err;
      job_cnt_nxt   = job_cnt;
`ifdef HLSM_HOST_TIMEOUT_EN
      tmo_cnt_nxt   = tmo_cnt;
`endif

      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               hs_a_nxt  = req_a;
               hs_b_nxt  = req_b;
               hs_c_nxt  = req_c;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            armed_nxt = 1'b0;
`ifdef HLSM_HOST_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            // A done level left over from the previous job only counts after a low sample.
            if (!hs_done)
               armed_nxt = 1'b1;
            if (armed && hs_done) begin
               rsp_z_nxt     = hs_z;
               rsp_x_nxt     = hs_x;
               rsp_err_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end
`ifdef HLSM_HOST_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               rsp_z_nxt     = '0;
               rsp_x_nxt     = '0;
               rsp_err_nxt   = 1'b1;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 16'd1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               job_cnt_nxt   = job_cnt + 16'd1;
               state_nxt     = IDLE;
            end
         end
      endcase

      // Flag outputs are registered copies of the upcoming state.
      req_ready_nxt = (state_nxt == IDLE);
      hs_start_nxt  = (state_nxt == LAUNCH);
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         req_ready <= 1'b1;
         hs_start  <= 1'b0;
         hs_a      <= '0;
         hs_b      <= '0;
         hs_c      <= '0;
         rsp_valid <= 1'b0;
         rsp_z     <= '0;
         rsp_x     <= '0;
         rsp_err   <= 1'b0;
         job_cnt   <= '0;
`ifdef HLSM_HOST_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         armed     <= armed_nxt;
         req_ready <= req_ready_nxt;
         hs_start  <= hs_start_nxt;
         hs_a      <= hs_a_nxt;
         hs_b      <= hs_b_nxt;
         hs_c      <= hs_c_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_z     <= rsp_z_nxt;
         rsp_x     <= rsp_x_nxt;
         rsp_err   <= rsp_err_nxt;
         job_cnt   <= job_cnt_nxt;
`ifdef HLSM_HOST_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_nxt;
`endif
      end
   end

endmodule
